pwm_duty_setpoint: RTL
======================

Name: pwm_duty_setpoint

Overview:
Upstream stage of the PWM generator: produces the duty word that the PWM block consumes on its duty input.
- Setpoint source 1: two push buttons (up/down), synchronised, debounced and edge-detected.
- Setpoint source 2: a parallel load port.
- A slew limiter ramps the output duty toward the setpoint, so LEDs fade and servos do not jump.

Parameters:
WIDTH, 8, width of duty/setpoint words
MAX_DUTY, 100, upper clamp of setpoint (duty units); must be < 2^WIDTH
STEP, 10, setpoint change per button press
DEB_CYCLES, 200000, consecutive stable cycles required to accept a button level (20 ms at 10 MHz)
RAMP_DIV, 10000, clock cycles per one-LSB duty step (1 ms at 10 MHz); must be >= 1

Ports:
clk_i  in  1  clock
rst_i  in  1  reset
btn_up_i  in  1  raw async button, active-high, increment
btn_dn_i  in  1  raw async button, active-high, decrement
load_i  in  1  synchronous strobe: load load_val_i into setpoint
load_val_i  in  WIDTH  value to load
setpoint_o  out  WIDTH  current setpoint register
duty_o  out  WIDTH  slew-limited duty, feeds PWM duty input
busy_o  out  1  high while duty_o != setpoint_o
at_target_o  out  1  one-cycle pulse when a ramp step makes duty_o equal setpoint_o

Behaviour:
Reset and clocking:
- Reset rst_i, asynchronous, active-high; clock clk_i.
- Every register clears to 0 on reset: sync FFs, debounce counters, stable levels, press pulses, setpoint, duty, prescaler, at_target.
- Reset values of outputs: setpoint_o=0, duty_o=0, busy_o=0, at_target_o=0.

Synchroniser:
- Two-FF synchroniser per button.
- All later logic uses the second FF only.

Debounce (per button):
- Counter runs while the synced level differs from the stable level.
- Counter clears to 0 whenever the synced level equals the stable level.
- When the counter reaches DEB_CYCLES-1 with the mismatch still present, stable takes the synced level and the counter clears.
- Press pulse is registered high for one cycle on the same edge that stable goes 0->1. Release generates no pulse.

Latency:
- Raw input sampled high at edge k, no bounce -> setpoint updates at edge k+DEB_CYCLES+2.

Setpoint update, priority in one cycle:
- load_i: setpoint = min(load_val_i, MAX_DUTY). Any button pulse in the same cycle is dropped.
- Up pulse only: setpoint = min(setpoint+STEP, MAX_DUTY). Compute in WIDTH+1 bits; no wrap.
- Down pulse only: setpoint = (setpoint < STEP) ? 0 : setpoint-STEP.
- Up and down pulses together: setpoint unchanged.

Ramp:
- Prescaler counts 0..RAMP_DIV-1 free-running; tick when count == RAMP_DIV-1.
- On tick: if duty < setpoint, duty+1; if duty > setpoint, duty-1; if equal, hold.
- Setpoint changes mid-ramp: the ramp redirects on the next tick; duty never overshoots.
- at_target_o is registered high on the edge where a tick step makes duty == setpoint (setpoint sampled that cycle).
- No pulse if equality arises from a setpoint change alone.
- busy_o = (duty_o != setpoint_o), combinational from registers.

Reset mid-operation:
- All state returns to 0 immediately (asynchronous).
- First ramp tick after release occurs RAMP_DIV cycles later.

Optional Feature:
PWM_SLEW_EN.
- Defined: ramp/prescaler behaviour as above.
- Undefined: no prescaler. duty_o is registered from setpoint every cycle, so duty_o equals setpoint_o one cycle after any setpoint change.
- Undefined: busy_o is high only during that cycle; at_target_o is tied 0.

Test Plan:
Bench parameters: DEB_CYCLES=4, RAMP_DIV=4, STEP=10, MAX_DUTY=100.
- Reset, then 3 clean btn_up presses (high 10 cycles, low 10 cycles) -> setpoint_o 0->10->20->30, each update 6 edges after input sampled high; duty_o ramps 1 LSB every 4 cycles to 30; at_target_o single pulse; busy_o low afterwards.
- btn_up bounce: high 3 cycles, low 2, high 3, low -> setpoint_o unchanged.
- Saturation: load 95 then up press -> 100; another up press -> 100. Load 5 then down press -> 0; down press again -> 0.
- load_val_i=250 -> setpoint_o=100. Same cycle as an up pulse -> still 100 (load wins). Simultaneous up+down pulses -> setpoint unchanged.
- Redirect: setpoint 40 while duty=10 ramping up, then load 20 at duty=25 -> duty reverses on next tick and reaches 20 exactly; one at_target_o pulse.
- Reset asserted mid-ramp (duty=17) -> all outputs 0 asynchronously. With PWM_SLEW_EN undefined: load 60 -> duty_o=60 one cycle later, at_target_o stays 0.

Source files
------------

// File: rtl/pwm_duty_setpoint_if.sv
// pwm_duty_setpoint_if: button, load and duty-output signals of pwm_duty_setpoint.
interface pwm_duty_setpoint_if #(parameter int WIDTH = 8);
    logic             btn_up;
    logic             btn_dn;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] setpoint;
    logic [WIDTH-1:0] duty;
    logic             busy;
    logic             at_target;
    modport master (output btn_up, btn_dn, load, load_val, input setpoint, duty, busy, at_target);
    modport slave (input btn_up, btn_dn, load, load_val, output setpoint, duty, busy, at_target);
endinterface

// File: rtl/pwm_duty_setpoint.sv
// pwm_duty_setpoint: debounced up/down buttons and a load port set a clamped setpoint; duty follows it.
// PWM_SLEW_EN: when defined duty ramps one LSB per RAMP_DIV cycles, otherwise duty follows setpoint next cycle.
module pwm_duty_setpoint #(
    parameter int WIDTH      = 8,
    parameter int MAX_DUTY   = 100,
    parameter int STEP       = 10,
    parameter int DEB_CYCLES = 200000,
    parameter int RAMP_DIV   = 10000
) (
    input logic clk_i,
    input logic rst_i,
    pwm_duty_setpoint_if.slave bus
);
    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam logic [WIDTH-1:0] MAX = WIDTH'(MAX_DUTY);
    if (RAMP_DIV < 1 || MAX_DUTY >= 2 ** WIDTH || DEB_CYCLES < 1) begin : g_bad_cfg
        $error("pwm_duty_setpoint: invalid parameters");
    end
    logic [1:0]           raw, sync1, sync2, stable, press;
    logic [1:0][DW-1:0]   cnt;
    logic [WIDTH-1:0]     setpoint, duty, sp_next, up_val, dn_val;
    logic [WIDTH:0]       sum;
    logic                 at_target;
    assign raw = {bus.btn_dn, bus.btn_up};
    always_comb begin
        sum     = {1'b0, setpoint} + (WIDTH+1)'(STEP);
        up_val  = (sum > (WIDTH+1)'(MAX_DUTY)) ? MAX : sum[WIDTH-1:0];
        dn_val  = (setpoint < WIDTH'(STEP)) ? '0 : setpoint - WIDTH'(STEP);
        sp_next = bus.load ? ((bus.load_val > MAX) ? MAX : bus.load_val)
                : (press == 2'b01) ? up_val
                : (press == 2'b10) ? dn_val : setpoint;
    end
    // bit 0 is the up button, bit 1 the down button
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1    <= '0;
            sync2    <= '0;
            stable   <= '0;
            press    <= '0;
            cnt      <= '0;
            setpoint <= '0;
        end else begin
            sync1    <= raw;
            sync2    <= sync1;
            setpoint <= sp_next;
            for (int j = 0; j < 2; j++) begin
                press[j] <= sync2[j] & ~stable[j] & (cnt[j] == DW'(DEB_CYCLES - 1));
                if (sync2[j] == stable[j]) begin
                    cnt[j] <= '0;
                end else if (cnt[j] == DW'(DEB_CYCLES - 1)) begin
                    stable[j] <= sync2[j];
                    cnt[j]    <= '0;
                end else begin
                    cnt[j] <= cnt[j] + DW'(1);
                end
            end
        end
    end
`ifdef PWM_SLEW_EN
    localparam int PW = $clog2(RAMP_DIV + 1);
    logic [PW-1:0]    pre;
    logic             tick;
    logic [WIDTH-1:0] duty_next;
    always_comb begin
        tick      = pre == PW'(RAMP_DIV - 1);
        duty_next = !tick ? duty
                  : (duty < setpoint) ? duty + 1'b1
                  : (duty > setpoint) ? duty - 1'b1 : duty;
    end
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pre       <= '0;
            duty      <= '0;
            at_target <= 1'b0;
        end else begin
            pre       <= tick ? '0 : pre + PW'(1);
            duty      <= duty_next;
            at_target <= (duty != setpoint) && (duty_next == setpoint);
        end
    end
`else
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) duty <= '0;
        else duty <= setpoint;
    end
    assign at_target = 1'b0;
`endif
    assign bus.setpoint  = setpoint;
    assign bus.duty      = duty;
    assign bus.busy      = duty != setpoint;
    assign bus.at_target = at_target;
endmodule
